// File: rtl/hier_icache_flush_seq.sv
// Hierarchical instruction-cache flush sequencer.
// Flushes the shared L2 banks first, then the selected private L1 caches,
// with either full or single-address (selective) flush requests.
module hier_icache_flush_seq #(
  parameter int NB_CACHE_BANKS = 4,
  parameter int NB_CORES       = 9
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_sel_i,
  input  logic [31:0]               cmd_addr_i,
  input  logic [NB_CORES-1:0]       cmd_core_mask_i,
  input  logic                      cmd_l2_en_i,
  output logic [NB_CACHE_BANKS-1:0] l2_flush_req_o,
  output logic [NB_CACHE_BANKS-1:0] l2_sel_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] l2_ack_i,
  output logic [NB_CORES-1:0]       l1_flush_req_o,
  output logic [NB_CORES-1:0]       l1_sel_flush_req_o,
  input  logic [NB_CORES-1:0]       l1_ack_i,
  output logic [31:0]               sel_flush_addr_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               last_cycles_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L2   = 2'd1,
    L1   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state;
  logic                      sel_q;
  logic [31:0]               addr_q;
  logic [NB_CORES-1:0]       mask_q;
  logic [NB_CACHE_BANKS-1:0] l2_pending;
  logic [NB_CORES-1:0]       l1_pending;
  logic [15:0]               count;
  logic [15:0]               last_cycles;

  logic [NB_CACHE_BANKS-1:0] l2_next;
  logic [NB_CORES-1:0]       l1_next;
  logic [15:0]               count_inc;

  // Pending bits are only ever nonzero in their own phase, so an ack on a
  // bit whose request is low simply has nothing to clear.
  always_comb begin
    l2_next   = l2_pending & ~l2_ack_i;
    l1_next   = l1_pending & ~l1_ack_i;
    count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
  end

  // Sequencer: command latch, L2 then L1 phase, completion bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      mask_q      <= '0;
      l2_pending  <= '0;
      l1_pending  <= '0;
      count       <= '0;
      last_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            sel_q  <= cmd_sel_i;
            addr_q <= cmd_addr_i;
            mask_q <= cmd_core_mask_i;
            count  <= '0;
            if (cmd_l2_en_i) begin
              state      <= L2;
              l2_pending <= '1;
            end else if (cmd_core_mask_i != '0) begin
              state      <= L1;
              l1_pending <= cmd_core_mask_i;
            end else begin
              state <= DONE;
            end
          end
        end
        L2: begin
          count      <= count_inc;
          l2_pending <= l2_next;
          if (l2_next == '0) begin
            if (mask_q != '0) begin
              state      <= L1;
              l1_pending <= mask_q;
            end else begin
              state <= DONE;
            end
          end
        end
        L1: begin
          count      <= count_inc;
          l1_pending <= l1_next;
          if (l1_next == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          count       <= count_inc;
          last_cycles <= count_inc;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure functions of registered state; the unselected request
  // type is forced low.
  always_comb begin
    cmd_ready_o        = (state == IDLE);
    busy_o             = (state != IDLE);
    done_o             = (state == DONE);
    l2_flush_req_o     = sel_q ? '0 : l2_pending;
    l2_sel_flush_req_o = sel_q ? l2_pending : '0;
    l1_flush_req_o     = sel_q ? '0 : l1_pending;
    l1_sel_flush_req_o = sel_q ? l1_pending : '0;
    sel_flush_addr_o   = addr_q;
    last_cycles_o      = last_cycles;
  end

endmodule

// File: tb/tb_hier_icache_flush_seq.sv
// Randomized bench for hier_icache_flush_seq with ack-responder agents and a
// transaction-level model of operation duration and request coverage.
module tb_hier_icache_flush_seq;
  localparam int NB = 4;
  localparam int NC = 9;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_sel_i;
  logic [31:0]   cmd_addr_i;
  logic [NC-1:0] cmd_core_mask_i;
  logic          cmd_l2_en_i;
  logic [NB-1:0] l2_flush_req_o;
  logic [NB-1:0] l2_sel_flush_req_o;
  logic [NB-1:0] l2_ack_i;
  logic [NC-1:0] l1_flush_req_o;
  logic [NC-1:0] l1_sel_flush_req_o;
  logic [NC-1:0] l1_ack_i;
  logic [31:0]   sel_flush_addr_o;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   last_cycles_o;

  int checks = 0;
  int failures = 0;

  // Responder configuration and bookkeeping
  int            d_l2[NB];
  int            d_l1[NC];
  int            hc_l2[NB];
  int            hc_l1[NC];
  bit            level_mode = 1'b0;
  bit            noise_en = 1'b0;
  logic [NB-1:0] acked2 = '0;
  logic [NC-1:0] acked1 = '0;
  int            done_cnt = 0;

  // Currently latched command as the bench understands it
  logic          op_sel = 1'b0;
  logic [31:0]   op_addr = '0;
  logic [NC-1:0] op_mask = '0;
  logic          op_l2en = 1'b0;

  hier_icache_flush_seq #(.NB_CACHE_BANKS(NB), .NB_CORES(NC)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cmd_valid_i        (cmd_valid_i),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_sel_i          (cmd_sel_i),
    .cmd_addr_i         (cmd_addr_i),
    .cmd_core_mask_i    (cmd_core_mask_i),
    .cmd_l2_en_i        (cmd_l2_en_i),
    .l2_flush_req_o     (l2_flush_req_o),
    .l2_sel_flush_req_o (l2_sel_flush_req_o),
    .l2_ack_i           (l2_ack_i),
    .l1_flush_req_o     (l1_flush_req_o),
    .l1_sel_flush_req_o (l1_sel_flush_req_o),
    .l1_ack_i           (l1_ack_i),
    .sel_flush_addr_o   (sel_flush_addr_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .last_cycles_o      (last_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ack responders: each bank/core acks d cycles after its request first
  // appears (pulse or level style); low requests may see random stray acks.
  initial begin
    logic [NB-1:0] req2;
    logic [NC-1:0] req1;
    logic [NB-1:0] a2;
    logic [NC-1:0] a1;
    l2_ack_i = '0;
    l1_ack_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        for (int k = 0; k < NB; k++) hc_l2[k] = 0;
        for (int k = 0; k < NC; k++) hc_l1[k] = 0;
        l2_ack_i = noise_en ? 4'($urandom) : '0;
        l1_ack_i = noise_en ? 9'($urandom) : '0;
        continue;
      end
      req2 = l2_flush_req_o | l2_sel_flush_req_o;
      req1 = l1_flush_req_o | l1_sel_flush_req_o;
      if (done_o) done_cnt++;
      checkOutput("ready_vs_busy", cmd_ready_o, !busy_o);
      checkOutput("addr", sel_flush_addr_o, op_addr);
      checkOutput("unsel_type", op_sel ? {l2_flush_req_o, l1_flush_req_o}
                                       : {l2_sel_flush_req_o, l1_sel_flush_req_o}, '0);
      checkOutput("l1_mask", req1 & ~op_mask, '0);
      checkOutput("l2_req_en", req2 & ~{NB{op_l2en}}, '0);
      if (|req1 && op_l2en) checkOutput("l1_before_l2_done", acked2, {NB{1'b1}});
      for (int k = 0; k < NB; k++) begin
        if (acked2[k]) checkOutput("l2_req_after_ack", req2[k], 1'b0);
        if (req2[k]) begin
          a2[k] = level_mode ? (hc_l2[k] >= d_l2[k]) : (hc_l2[k] == d_l2[k]);
          hc_l2[k]++;
          if (a2[k]) acked2[k] = 1'b1;
        end else begin
          hc_l2[k] = 0;
          a2[k] = noise_en ? 1'($urandom) : 1'b0;
        end
      end
      for (int k = 0; k < NC; k++) begin
        if (acked1[k]) checkOutput("l1_req_after_ack", req1[k], 1'b0);
        if (req1[k]) begin
          a1[k] = level_mode ? (hc_l1[k] >= d_l1[k]) : (hc_l1[k] == d_l1[k]);
          hc_l1[k]++;
          if (a1[k]) acked1[k] = 1'b1;
        end else begin
          hc_l1[k] = 0;
          a1[k] = noise_en ? 1'($urandom) : 1'b0;
        end
      end
      l2_ack_i = a2;
      l1_ack_i = a1;
    end
  end

  task automatic setDelays(input int maxd);
    for (int k = 0; k < NB; k++) d_l2[k] = $urandom_range(0, maxd);
    for (int k = 0; k < NC; k++) d_l1[k] = $urandom_range(0, maxd);
  endtask

  // Issue one command (called at posedge+2) and check the whole operation.
  task automatic applyStimulus(input logic sel, input logic [31:0] addr,
                               input logic [NC-1:0] mask, input logic l2en);
    int m2, m1, exp_cycles, cyc, bound;
    m2 = 0;
    for (int k = 0; k < NB; k++) if (d_l2[k] > m2) m2 = d_l2[k];
    m1 = 0;
    for (int k = 0; k < NC; k++) if (mask[k] && d_l1[k] > m1) m1 = d_l1[k];
    exp_cycles = (l2en ? m2 + 1 : 0) + ((mask != '0) ? m1 + 1 : 0) + 1;
    bound = exp_cycles + 20;
    acked2 = '0;
    acked1 = '0;
    done_cnt = 0;
    cmd_valid_i = 1'b1;
    cmd_sel_i = sel;
    cmd_addr_i = addr;
    cmd_core_mask_i = mask;
    cmd_l2_en_i = l2en;
    @(posedge clk_i);
    #2;
    op_sel = sel;
    op_addr = addr;
    op_mask = mask;
    op_l2en = l2en;
    cmd_valid_i = 1'b0;
    cmd_sel_i = 1'($urandom);
    cmd_addr_i = $urandom;
    cmd_core_mask_i = 9'($urandom);
    cmd_l2_en_i = 1'($urandom);
    cyc = 0;
    while (busy_o === 1'b1 && cyc < bound) begin
      cyc++;
      @(posedge clk_i);
      #2;
    end
    if (cyc >= bound) checkOutput("done_timeout", 1'b0, 1'b1);
    checkOutput("busy_cycles", cyc, exp_cycles);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("done_after", done_o, 1'b0);
    checkOutput("ready_after", cmd_ready_o, 1'b1);
    checkOutput("last_cycles", last_cycles_o, (exp_cycles > 65535) ? 65535 : exp_cycles);
    checkOutput("l2_acked", acked2, l2en ? {NB{1'b1}} : '0);
    checkOutput("l1_acked", acked1, mask);
  endtask

  initial begin
    int w;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_sel_i = 1'b0;
    cmd_addr_i = '0;
    cmd_core_mask_i = '0;
    cmd_l2_en_i = 1'b0;
    for (int k = 0; k < NB; k++) d_l2[k] = 2;
    for (int k = 0; k < NC; k++) d_l1[k] = 2;
    #1;
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_reqs", {l2_flush_req_o, l2_sel_flush_req_o, l1_flush_req_o, l1_sel_flush_req_o}, '0);
    checkOutput("rst_addr", sel_flush_addr_o, '0);
    checkOutput("rst_last", last_cycles_o, '0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    checkOutput("ready_after_rst", cmd_ready_o, 1'b1);

    // Full flush, everything acks 2 cycles after request
    applyStimulus(1'b0, 32'h0, 9'h1FF, 1'b1);
    // Selective flush L1 only on cores 0 and 2
    applyStimulus(1'b1, 32'h1C00_8040, 9'h005, 1'b0);
    checkOutput("sel_addr_hold", sel_flush_addr_o, 32'h1C00_8040);
    // Empty command goes straight to DONE
    applyStimulus(1'b0, 32'h1234_5678, 9'h000, 1'b0);
    // Staggered L2 acks 3,0,2,1 with bank 1 late
    d_l2[0] = 2; d_l2[1] = 20; d_l2[2] = 4; d_l2[3] = 1;
    for (int k = 0; k < NC; k++) d_l1[k] = 0;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 9'h1A3, 1'b1);
    // L2 only, and same-cycle acks on the first request cycle
    for (int k = 0; k < NB; k++) d_l2[k] = 0;
    applyStimulus(1'b0, 32'h0000_0100, 9'h000, 1'b1);

    // Randomized commands with pulse/level acks and stray-ack noise
    for (int i = 0; i < 30; i++) begin
      setDelays(6);
      level_mode = 1'($urandom);
      noise_en = 1'($urandom);
      case ($urandom_range(0, 3))
        0: applyStimulus(1'($urandom), $urandom, 9'h000, 1'($urandom));
        1: applyStimulus(1'($urandom), $urandom, 9'h1FF, 1'($urandom));
        default: applyStimulus(1'($urandom), $urandom, 9'($urandom), 1'($urandom));
      endcase
    end

    // Reset during the L1 phase aborts without a done pulse
    level_mode = 1'b0;
    noise_en = 1'b1;
    for (int k = 0; k < NB; k++) d_l2[k] = 1;
    for (int k = 0; k < NC; k++) d_l1[k] = 30;
    acked2 = '0;
    acked1 = '0;
    done_cnt = 0;
    cmd_valid_i = 1'b1;
    cmd_sel_i = 1'b0;
    cmd_addr_i = 32'hCAFE_0000;
    cmd_core_mask_i = 9'h1FF;
    cmd_l2_en_i = 1'b1;
    @(posedge clk_i);
    #2;
    op_sel = 1'b0;
    op_addr = 32'hCAFE_0000;
    op_mask = 9'h1FF;
    op_l2en = 1'b1;
    cmd_valid_i = 1'b0;
    w = 0;
    while (!(|(l1_flush_req_o | l1_sel_flush_req_o)) && w < 40) begin
      @(posedge clk_i);
      #2;
      w++;
    end
    checkOutput("l1_reached", (w < 40), 1'b1);
    #1;
    rst_i = 1'b1;
    op_addr = '0;
    #1;
    checkOutput("abort_reqs", {l2_flush_req_o, l2_sel_flush_req_o, l1_flush_req_o, l1_sel_flush_req_o}, '0);
    checkOutput("abort_busy", busy_o, 1'b0);
    checkOutput("abort_done", done_o, 1'b0);
    checkOutput("abort_addr", sel_flush_addr_o, '0);
    checkOutput("abort_last", last_cycles_o, '0);
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i);
      #2;
      checkOutput("stray_ack_busy", busy_o, 1'b0);
    end
    checkOutput("abort_no_done", done_cnt, 0);
    noise_en = 1'b0;
    setDelays(3);
    applyStimulus(1'b1, 32'h0BAD_F00D, 9'h0F0, 1'b1);

    // Counter saturation: bank 0 stalls beyond 16 bits of cycles
    for (int k = 0; k < NB; k++) d_l2[k] = 1;
    d_l2[0] = 66000;
    for (int k = 0; k < NC; k++) d_l1[k] = 1;
    applyStimulus(1'b0, 32'h0, 9'h003, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
